// File: rtl/wildmatch_table.sv
// Clocked wildcard-match lookup table: value/care patterns searched by a
// two-stage valid/ready pipeline. Define WILDMATCH_HITCNT_EN to add hit_count.
module wildmatch_table #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8,
    localparam int IDXW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDXW-1:0]  wr_idx,
    input  logic [WIDTH-1:0] wr_value,
    input  logic [WIDTH-1:0] wr_care,
    input  logic             wr_live,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_key,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_hit,
    output logic [IDXW-1:0]  resp_idx,
    output logic [DEPTH-1:0] resp_vec
`ifdef WILDMATCH_HITCNT_EN
    ,
    output logic [15:0]      hit_count
`endif
);

    logic [DEPTH-1:0] live;
    logic [WIDTH-1:0] value [DEPTH];
    logic [WIDTH-1:0] care  [DEPTH];

    logic [DEPTH-1:0] match_vec;
    logic             s1_valid;
    logic [DEPTH-1:0] s1_vec;
    logic [IDXW-1:0]  enc_idx;
    logic             out_adv;
    logic             s1_adv;

    assign out_adv   = !resp_valid || resp_ready;
    assign s1_adv    = !s1_valid || out_adv;
    assign req_ready = s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            live <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                value[i] <= '0;
                care[i]  <= '0;
            end
        end else if (wr_en) begin
            live[wr_idx]  <= wr_live;
            value[wr_idx] <= wr_value;
            care[wr_idx]  <= wr_care;
        end
    end

    // Compared against the pre-edge table, so a same-cycle write is not seen.
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = live[i] && (((req_key ^ value[i]) & care[i]) == '0);
        end
    end

    always_comb begin
        enc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (s1_vec[i]) begin
                enc_idx = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_vec   <= '0;
        end else if (s1_adv) begin
            s1_valid <= req_valid;
            if (req_valid) begin
                s1_vec <= match_vec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_idx   <= '0;
            resp_vec   <= '0;
        end else if (out_adv) begin
            resp_valid <= s1_valid;
            if (s1_valid) begin
                resp_hit <= |s1_vec;
                resp_idx <= enc_idx;
                resp_vec <= s1_vec;
            end
        end
    end

`ifdef WILDMATCH_HITCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count <= '0;
        end else if (resp_valid && resp_ready && resp_hit && hit_count != 16'hFFFF) begin
            hit_count <= hit_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wildmatch_table.sv
// Scoreboard bench for wildmatch_table: a table model predicts each match
// vector at acceptance; a negedge monitor pops and compares responses.
module tb_wildmatch_table;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_idx = '0;
    logic [8:0] wr_value = '0;
    logic [8:0] wr_care = '0;
    logic       wr_live = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [8:0] req_key = '0;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic       resp_hit;
    logic [2:0] resp_idx;
    logic [7:0] resp_vec;
`ifdef WILDMATCH_HITCNT_EN
    logic [15:0] hit_count;
`endif

    wildmatch_table dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_value(wr_value), .wr_care(wr_care), .wr_live(wr_live),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hit(resp_hit), .resp_idx(resp_idx), .resp_vec(resp_vec)
`ifdef WILDMATCH_HITCNT_EN
        , .hit_count(hit_count)
`endif
    );

    always #5 clk = ~clk;

    int assertions = 0;
    int failures = 0;
    int cycle = 0;
    int model_hits = 0;

    logic [7:0] m_live;
    logic [8:0] m_value [8];
    logic [8:0] m_care  [8];
    logic [7:0] exp_q [$];
    int         pop_cycles [$];
    logic       stalled = 1'b0;
    logic [31:0] held;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    function automatic logic [7:0] modelMatch(input logic [8:0] key);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) begin
            v[i] = m_live[i] && ((key & m_care[i]) == (m_value[i] & m_care[i]));
        end
        return v;
    endfunction

    function automatic logic [2:0] modelIdx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    // Handshakes are judged at negedge, where inputs and outputs are settled.
    always @(negedge clk) begin
        logic [7:0] e;
        cycle++;
        if (rst) begin
            exp_q.delete();
            m_live = '0;
            for (int i = 0; i < 8; i++) begin
                m_value[i] = '0;
                m_care[i]  = '0;
            end
            stalled = 1'b0;
            model_hits = 0;
        end else begin
            if (resp_valid) begin
                if (stalled) begin
                    checkOutput("stall_stable", {20'd0, resp_hit, resp_idx, resp_vec}, held);
                end
                if (resp_ready) begin
                    stalled = 1'b0;
                    pop_cycles.push_back(cycle);
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("resp_vec", {24'd0, resp_vec}, {24'd0, e});
                        checkOutput("resp_hit", {31'd0, resp_hit}, {31'd0, |e});
                        checkOutput("resp_idx", {29'd0, resp_idx}, {29'd0, modelIdx(e)});
                        if (|e && model_hits < 65535) model_hits++;
                    end
                end else begin
                    stalled = 1'b1;
                    held = {20'd0, resp_hit, resp_idx, resp_vec};
                end
            end else begin
                stalled = 1'b0;
            end
            if (req_valid && req_ready) exp_q.push_back(modelMatch(req_key));
            if (wr_en) begin
                m_live[wr_idx]  = wr_live;
                m_value[wr_idx] = wr_value;
                m_care[wr_idx]  = wr_care;
            end
        end
    end

    // Drives one cycle of inputs; a request is held until it is accepted.
    task automatic applyStimulus(input logic we, input logic [2:0] idx, input logic [8:0] val,
                                 input logic [8:0] cm, input logic lv,
                                 input logic rv, input logic [8:0] key);
        int n = 0;
        @(posedge clk);
        #1;
        wr_en = we; wr_idx = idx; wr_value = val; wr_care = cm; wr_live = lv;
        req_valid = rv; req_key = key;
        @(negedge clk);
        while (rv && !req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rv && !req_ready) checkOutput("req_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 3'd0, 9'h0, 9'h0, 1'b0, 1'b0, 9'h0);
    endtask

    task automatic search(input logic [8:0] key);
        applyStimulus(1'b0, 3'd0, 9'h0, 9'h0, 1'b0, 1'b1, key);
    endtask

    task automatic write(input logic [2:0] idx, input logic [8:0] val, input logic [8:0] cm, input logic lv);
        applyStimulus(1'b1, idx, val, cm, lv, 1'b0, 9'h0);
    endtask

    task automatic waitIdle();
        int n = 0;
        idle();
        while ((exp_q.size() != 0 || resp_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", {31'd0, (exp_q.size() != 0 || resp_valid)}, 32'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1; req_valid = 1'b0; wr_en = 1'b0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("reset_resp_hit", {31'd0, resp_hit}, 32'd0);
        checkOutput("reset_resp_idx", {29'd0, resp_idx}, 32'd0);
        checkOutput("reset_resp_vec", {24'd0, resp_vec}, 32'd0);

        // Empty table: miss, two-cycle latency.
        search(9'h0AB);
        idle();
        checkOutput("latency_n1_valid", {31'd0, resp_valid}, 32'd0);
        idle();
        checkOutput("latency_n2_valid", {31'd0, resp_valid}, 32'd1);
        checkOutput("empty_vec", {24'd0, resp_vec}, 32'h00);
        waitIdle();

        write(3'd3, 9'h1F0, 9'h1F0, 1'b1);
        search(9'h1F7);
        search(9'h0F7);
        waitIdle();

        write(3'd5, 9'h1AA, 9'h000, 1'b1);
        write(3'd2, 9'h055, 9'h1FF, 1'b1);
        search(9'h055);
        write(3'd2, 9'h055, 9'h1FF, 1'b0);
        search(9'h055);
        waitIdle();

        // Write and search in the same cycle: the search sees the old entry.
        applyStimulus(1'b1, 3'd1, 9'h012, 9'h1FF, 1'b1, 1'b1, 9'h012);
        search(9'h012);
        waitIdle();

        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        fork
            begin
                search(9'h1F3);
                search(9'h012);
                search(9'h155);
                idle();
            end
            begin
                repeat (6) @(negedge clk);
                checkOutput("stall_req_ready", {31'd0, req_ready}, 32'd0);
                checkOutput("stall_inflight", exp_q.size(), 32'd2);
                checkOutput("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
                pop_cycles.delete();
                @(posedge clk);
                #1;
                resp_ready = 1'b1;
            end
        join
        waitIdle();
        checkOutput("release_count", pop_cycles.size(), 32'd3);
        if (pop_cycles.size() == 3) begin
            checkOutput("release_gap01", pop_cycles[1] - pop_cycles[0], 32'd1);
            checkOutput("release_gap12", pop_cycles[2] - pop_cycles[1], 32'd1);
        end

        doReset();
        write(3'd0, 9'h100, 9'h1FF, 1'b1);
        for (int i = 0; i < 6; i++) search(i < 4 ? 9'h100 : 9'h001);
        waitIdle();
`ifdef WILDMATCH_HITCNT_EN
        checkOutput("hit_count_4", {16'd0, hit_count}, 32'd4);
        checkOutput("hit_count_model", {16'd0, hit_count}, model_hits);
`endif

        search(9'h100);
        search(9'h100);
        doReset();
        checkOutput("midreset_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("midreset_req_ready", {31'd0, req_ready}, 32'd1);
`ifdef WILDMATCH_HITCNT_EN
        checkOutput("midreset_hit_count", {16'd0, hit_count}, 32'd0);
`endif
        search(9'h100);
        idle();
        idle();
        checkOutput("midreset_table_empty", {31'd0, resp_hit}, 32'd0);
        waitIdle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
